// File: rtl/mp64_tile_reduce.sv
// Multi-tile reduction engine: streams TILE_BITS-wide tiles from the tile memory
// port and folds every element into one 64-bit accumulator (SUM/MIN/MAX/POPCNT/L1).
module mp64_tile_reduce #(
  parameter int TILE_BITS = 512,
  parameter int ADDR_W    = 20,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [1:0]           ew,
  input  logic                 signed_mode,
  input  logic                 acc_keep,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    stride,
  input  logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [63:0]          acc_out,
  output logic                 tile_req,
  output logic [ADDR_W-1:0]    tile_addr,
  input  logic [TILE_BITS-1:0] tile_rdata,
  input  logic                 tile_ack
);

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | tile_req pulse for tile i
  // WAIT  | waiting for tile_ack
  // RED   | fold registered tile into acc
  // DONE  | done (and err) pulse
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RED, S_DONE} state_t;

  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_MIN = 3'd1;
  localparam logic [2:0] OP_MAX = 3'd2;
  localparam logic [2:0] OP_POP = 3'd3;
  localparam logic [2:0] OP_L1  = 3'd4;

  state_t                state_q;
  logic [2:0]            op_q;
  logic [1:0]            ew_q;
  logic                  sgn_q;
  logic [ADDR_W-1:0]     stride_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      idx_q;
  logic [TILE_BITS-1:0]  data_q;
  logic [63:0]           acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  req_q;
  logic [ADDR_W-1:0]     taddr_q;
  logic [63:0]           red_d;
  logic [CNT_W-1:0]      idx_d;
  logic [ADDR_W-1:0]     addr_d;

  function automatic logic [63:0] width_mask(input logic [1:0] w);
    case (w)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] w,
                                         input logic sgn);
    logic [63:0] m;
    logic        msb;
    m   = width_mask(w);
    msb = |(raw & (m ^ (m >> 1)));
    return (sgn && msb) ? (raw | ~m) : (raw & m);
  endfunction

  // Identity for MIN/MAX is the extreme representable value at the element width.
  function automatic logic [63:0] seed(input logic [2:0] o, input logic [1:0] w,
                                       input logic sgn);
    logic [63:0] m;
    m = width_mask(w);
    case (o)
      OP_MIN:  return sgn ? (m >> 1) : m;
      OP_MAX:  return sgn ? ~(m >> 1) : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] fold(input logic [63:0] acc, input logic [63:0] x,
                                       input logic [2:0] o, input logic sgn);
    logic lt;
    logic gt;
    lt = sgn ? ($signed(x) < $signed(acc)) : (x < acc);
    gt = sgn ? ($signed(x) > $signed(acc)) : (x > acc);
    case (o)
      OP_SUM:  return acc + x;
      OP_MIN:  return lt ? x : acc;
      OP_MAX:  return gt ? x : acc;
      OP_L1:   return acc + ((sgn && x[63]) ? (~x + 64'd1) : x);
      default: return acc;
    endcase
  endfunction

  always_comb begin
    red_d = acc_q;
    case (ew_q)
      2'd0: for (int j = 0; j < TILE_BITS / 8; j++)
              red_d = fold(red_d, extend({56'd0, data_q[j*8 +: 8]}, ew_q, sgn_q), op_q, sgn_q);
      2'd1: for (int j = 0; j < TILE_BITS / 16; j++)
              red_d = fold(red_d, extend({48'd0, data_q[j*16 +: 16]}, ew_q, sgn_q), op_q, sgn_q);
      2'd2: for (int j = 0; j < TILE_BITS / 32; j++)
              red_d = fold(red_d, extend({32'd0, data_q[j*32 +: 32]}, ew_q, sgn_q), op_q, sgn_q);
      default: for (int j = 0; j < TILE_BITS / 64; j++)
              red_d = fold(red_d, data_q[j*64 +: 64], op_q, sgn_q);
    endcase
    if (op_q == OP_POP) red_d = acc_q + 64'($countones(data_q));
  end

  assign idx_d  = idx_q + CNT_W'(1);
  assign addr_d = addr_q + stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      ew_q     <= 2'd0;
      sgn_q    <= 1'b0;
      stride_q <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      acc_q    <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      taddr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      req_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            ew_q     <= ew;
            sgn_q    <= signed_mode;
            stride_q <= stride;
            addr_q   <= base_addr;
            count_q  <= count;
            idx_q    <= '0;
            if (op > OP_L1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              if (!acc_keep) acc_q <= seed(op, ew, signed_mode);
              if (count == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_REQ;
                busy_q  <= 1'b1;
                req_q   <= 1'b1;
                taddr_q <= {base_addr[ADDR_W-1:6], 6'd0};
              end
            end
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (tile_ack) begin
            data_q  <= tile_rdata;
            state_q <= S_RED;
          end
        end
        S_RED: begin
          acc_q <= red_d;
          idx_q <= idx_d;
          if (idx_d == count_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= addr_d;
            taddr_q <= {addr_d[ADDR_W-1:6], 6'd0};
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign acc_out   = acc_q;
  assign tile_req  = req_q;
  assign tile_addr = taddr_q;

endmodule

// File: tb/tb_mp64_tile_reduce.sv
// Scoreboard bench for mp64_tile_reduce: directed reductions with hand-computed results,
// a 1-cycle-ack tile memory model and a monitor checking addresses, results and latency.
module tb_mp64_tile_reduce;

  localparam int TB = 512;
  localparam int AW = 20;
  localparam int CW = 5;

  typedef struct {
    logic [63:0] acc;
    logic        err;
    int          lat;
    int          s;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [1:0]    ew;
  logic          signed_mode;
  logic          acc_keep;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          err;
  logic [63:0]   acc_out;
  logic          tile_req;
  logic [AW-1:0] tile_addr;
  logic [TB-1:0] tile_rdata;
  logic          tile_ack;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int mem_delay = 0;
  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [TB-1:0] mem [int];

  mp64_tile_reduce #(.TILE_BITS(TB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ew(ew),
    .signed_mode(signed_mode), .acc_keep(acc_keep), .base_addr(base_addr),
    .stride(stride), .count(count), .busy(busy), .done(done), .err(err),
    .acc_out(acc_out), .tile_req(tile_req), .tile_addr(tile_addr),
    .tile_rdata(tile_rdata), .tile_ack(tile_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [TB-1:0] fill8(input logic [7:0] b);
    return {(TB/8){b}};
  endfunction

  // Tile memory: answers each request with one ack, mem_delay extra cycles late.
  initial begin
    logic [TB-1:0] d;
    int dly;
    tile_ack   = 1'b0;
    tile_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && tile_req) begin
        d   = mem.exists(int'(tile_addr)) ? mem[int'(tile_addr)] : '0;
        dly = mem_delay;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        tile_ack   = 1'b1;
        tile_rdata = d;
        @(posedge clk);
        #1;
        tile_ack   = 1'b0;
        tile_rdata = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tile_req) begin
        if (addr_q.size() == 0) chk("unexpected_tile_req", 64'(tile_addr), 64'hDEAD);
        else chk("tile_addr", 64'(tile_addr), 64'(addr_q.pop_front()));
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", acc_out, ~acc_out);
        end else begin
          e = exp_q.pop_front();
          chk("acc_out", acc_out, e.acc);
          chk("err", 64'(err), 64'(e.err));
          chk("done_latency", 64'(cyc - e.s + 1), 64'(e.lat));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic wait_done();
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic run(input logic [2:0] o, input logic [1:0] w, input logic s, input logic k,
                     input logic [AW-1:0] b, input logic [AW-1:0] st, input logic [CW-1:0] c,
                     input logic [63:0] eacc, input logic eerr, input int elat);
    exp_t e;
    @(posedge clk);
    #1;
    op = o; ew = w; signed_mode = s; acc_keep = k;
    base_addr = b; stride = st; count = c; start = 1'b1;
    e.acc = eacc; e.err = eerr; e.lat = elat; e.s = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'd7; ew = ~w; signed_mode = ~s; acc_keep = ~k;
    base_addr = 20'hABCDE; stride = 20'h12345; count = 5'd31;
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_acc"}, acc_out, 64'd0);
    chk({tag, "_req"}, 64'(tile_req), 64'd0);
    chk({tag, "_addr"}, 64'(tile_addr), 64'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; ew = 2'd0; signed_mode = 1'b0;
    acc_keep = 1'b0; base_addr = '0; stride = '0; count = '0;
    mem[32'h00000] = fill8(8'h01);
    mem[32'h00040] = fill8(8'h02);
    mem[32'h00080] = fill8(8'h03);
    mem[32'h000C0] = fill8(8'h04);
    mem[32'h01000] = fill8(8'hFF);
    mem[32'h02000] = {{31{16'h0005}}, 16'hFFFE};
    mem[32'h03000] = fill8(8'hAA);
    mem[32'hFFFC0] = fill8(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    addr_q.push_back(20'h01000);
    run(3'd0, 2'd0, 1'b0, 1'b0, 20'h01005, 20'h00040, 5'd1, 64'd16320, 1'b0, 4);
    addr_q.push_back(20'h00000); addr_q.push_back(20'h00040);
    addr_q.push_back(20'h00080); addr_q.push_back(20'h000C0);
    run(3'd0, 2'd0, 1'b0, 1'b0, 20'h00000, 20'h00040, 5'd4, 64'd640, 1'b0, 13);
    addr_q.push_back(20'h02000);
    run(3'd1, 2'd1, 1'b1, 1'b0, 20'h02000, 20'h00040, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4);
    addr_q.push_back(20'h02000);
    run(3'd2, 2'd1, 1'b0, 1'b0, 20'h02000, 20'h00040, 5'd1, 64'h0000_0000_0000_FFFE, 1'b0, 4);
    addr_q.push_back(20'h02000);
    run(3'd4, 2'd1, 1'b1, 1'b0, 20'h02000, 20'h00040, 5'd1, 64'd157, 1'b0, 4);
    addr_q.push_back(20'h03000);
    run(3'd3, 2'd3, 1'b1, 1'b0, 20'h03000, 20'h00040, 5'd1, 64'd256, 1'b0, 4);
    addr_q.push_back(20'h03000);
    run(3'd3, 2'd0, 1'b0, 1'b1, 20'h03000, 20'h00040, 5'd1, 64'd512, 1'b0, 4);
    addr_q.push_back(20'h03000);
    run(3'd4, 2'd3, 1'b1, 1'b0, 20'h03000, 20'h00040, 5'd1, 64'hAAAA_AAAA_AAAA_AAB0, 1'b0, 4);
    addr_q.push_back(20'hFFFC0); addr_q.push_back(20'h00000);
    run(3'd0, 2'd2, 1'b1, 1'b0, 20'hFFFC0, 20'h00040, 5'd2, 64'h0000_0000_1010_1000, 1'b0, 7);
    run(3'd1, 2'd0, 1'b0, 1'b0, 20'h01000, 20'h00040, 5'd0, 64'h0000_0000_0000_00FF, 1'b0, 1);
    run(3'd6, 2'd0, 1'b0, 1'b0, 20'h01000, 20'h00040, 5'd3, 64'h0000_0000_0000_00FF, 1'b1, 1);
    run(3'd2, 2'd0, 1'b1, 1'b0, 20'h01000, 20'h00040, 5'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1);
    addr_q.push_back(20'h00040);
    run(3'd0, 2'd0, 1'b0, 1'b1, 20'h00040, 20'h00040, 5'd1, 64'd0, 1'b0, 4);

    // Abort while waiting for the ack; the late ack must not revive the operation.
    mem_delay = 4;
    addr_q.push_back(20'h01000);
    @(posedge clk);
    #1;
    op = 3'd0; ew = 2'd0; signed_mode = 1'b0; acc_keep = 1'b0;
    base_addr = 20'h01000; stride = 20'h00040; count = 5'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wait_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_delay = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_acc", acc_out, 64'd0);

    addr_q.push_back(20'h01000);
    run(3'd0, 2'd0, 1'b0, 1'b0, 20'h01000, 20'h00040, 5'd1, 64'd16320, 1'b0, 4);

    repeat (3) @(posedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mp64_tile_reduce.md
# mp64_tile_reduce

Parametrised multi-tile reduction engine for the MP64 tile subsystem. Given a base address, stride and tile count, it streams tiles from the tile memory port and folds every element into a single 64-bit accumulator. Supported reductions are SUM, MIN, MAX, POPCNT and L1, at 8/16/32/64-bit element width, signed or unsigned, with optional seeding from the current accumulator. It sits beside mp64_tile on the same tile memory arbiter and is started by the MEX dispatch path once the CSRs are decoded.

## Interface
- TILE_BITS, 512, tile width in bits (multiple of 64)
- ADDR_W, 20, tile memory byte-address width
- CNT_W, 5, width of the tile-count input

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  3  0=SUM 1=MIN 2=MAX 3=POPCNT 4=L1; 5–7 reserved
- ew  in  2  element width: 0=8, 1=16, 2=32, 3=64
- signed_mode  in  1  elements are two's-complement
- acc_keep  in  1  seed from current acc_out, not from the op identity
- base_addr  in  ADDR_W  first tile address
- stride  in  ADDR_W  address increment between tiles
- count  in  CNT_W  number of tiles to reduce
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done; reserved op
- acc_out  out  64  accumulator
- tile_req  out  1  one-cycle read request pulse
- tile_addr  out  ADDR_W  request address; bits [5:0] forced to 0
- tile_rdata  in  TILE_BITS  read data, valid with tile_ack
- tile_ack  in  1  read completion

## Operation
- All inputs are latched on an accepted start; later changes have no effect on the running operation.
- FSM states: IDLE, REQ, WAIT, RED, DONE.
  - IDLE + start: latch inputs and load the seed into acc.
    - Reserved op: go to DONE with err, acc unchanged.
    - count==0: go to DONE.
    - Otherwise: go to REQ.
  - REQ: pulse tile_req with tile_addr = base_addr + i*stride (mod 2^ADDR_W, low 6 bits zeroed). Go to WAIT.
  - WAIT: hold until tile_ack. On ack, register tile_rdata and go to RED.
  - RED: fold all TILE_BITS/width elements into acc in one cycle. Increment i. If i==count go to DONE, else go to REQ.
  - DONE: done=1 for one cycle, then IDLE.
- tile_ack is ignored outside WAIT. start is ignored outside IDLE.
- Element extension: each element is sign-extended (signed_mode=1) or zero-extended to 64 bits before use.
- SUM: acc += Σ elements, mod 2^64.
- MIN / MAX: 64-bit compare of extended values, signed or unsigned per signed_mode.
- POPCNT: acc += total set bits in the tile. ew and signed_mode are ignored.
- L1: acc += Σ|x| when signed, Σx when unsigned. |most-negative| wraps to the unsigned magnitude.
- Seed with acc_keep=0:
  - SUM, POPCNT, L1: 0.
  - MIN: maximum representable value at ew, extended (unsigned 8-bit → 0xFF; signed 8-bit → 0x7F).
  - MAX: minimum representable value at ew, extended (unsigned → 0; signed 8-bit → 0xFFFF_FFFF_FFFF_FF80).
- Seed with acc_keep=1: current acc_out.

## Timing
- Reset values: busy=0, done=0, err=0, acc_out=0, tile_req=0, tile_addr=0, FSM=IDLE.
- Reset mid-operation aborts immediately. An ack arriving after reset is ignored.
- busy=1 in REQ, WAIT and RED; 0 in IDLE and DONE.
- done and err are registered and high only in DONE.
- acc_out holds its final value from the DONE cycle until the next accepted start.
- Latency with a 1-cycle-ack memory, start sampled at edge 0:
  - tile_req at cycle 1, ack at cycle 2, RED at cycle 3.
  - count=N: done at cycle 3N+1.
  - count=0 or reserved op: done at cycle 1.
- At most one outstanding request. The next tile_req occurs no earlier than the cycle after RED.
- Address wraps silently at 2^ADDR_W.

## Test plan
- SUM, ew8 unsigned, count=1, tile of all 0xFF: acc_out=16320 (0x3FC0), done at cycle 4, exactly one tile_req.
- SUM, count=4, base 0x000, stride 0x40, tiles all 0x01/0x02/0x03/0x04: tile_addr sequence 0x000, 0x040, 0x080, 0x0C0; acc_out=640; done at cycle 13.
- ew16 tile of halfwords 0x0005 with one 0xFFFE:
  - signed MIN → 0xFFFF_FFFF_FFFF_FFFE.
  - unsigned MAX → 0xFFFE.
  - signed L1 → 31*5+2 = 157.
- POPCNT on an all-0xAA tile with acc_keep=0 → 256; repeated with acc_keep=1 → 512.
- count=0, MIN, ew8 unsigned → acc_out=0xFF, done at cycle 1, no tile_req. op=6 → done+err at cycle 1, acc_out unchanged.
- Reset asserted while in WAIT, with the ack delivered afterwards: all outputs at reset values and the ack ignored; the next start reduces correctly.
